// File: rtl/sdram_client_arbiter.sv
// Two-client SDRAM command arbiter: the processor owns the bus by default, and the
// display takes it over through a request/yield handshake with one idle gap cycle.
module sdram_client_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 22,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned YIELD_TIMEOUT = 1024,
    parameter int unsigned TIMEOUT_WIDTH = 11
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic [1:0]            i_Proc_Command,
    input  logic [ADDR_WIDTH-1:0] i_Proc_Address,
    input  logic [DATA_WIDTH-1:0] i_Proc_Data_Write,
    input  logic                  i_Proc_Yield,
    output logic                  o_Proc_Requested,
    output logic                  o_Proc_Read_Valid,
    output logic                  o_Proc_Write_Done,
    input  logic                  i_Disp_Request,
    input  logic [1:0]            i_Disp_Command,
    input  logic [ADDR_WIDTH-1:0] i_Disp_Address,
    output logic                  o_Disp_Grant,
    output logic                  o_Disp_Read_Valid,
    output logic [1:0]            o_Command,
    output logic [ADDR_WIDTH-1:0] o_Address,
    output logic [DATA_WIDTH-1:0] o_Data_Write,
    input  logic                  i_Read_Valid,
    input  logic                  i_Write_Done,
    output logic                  o_Starved
);

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_MAX = TIMEOUT_WIDTH'(YIELD_TIMEOUT);

    typedef enum logic [1:0] {
        S_PROC  = 2'd0,
        S_GAP_D = 2'd1,
        S_DISP  = 2'd2,
        S_GAP_P = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_next;
    logic                     starved;

    // State, wait counter and sticky starvation flag
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= S_PROC;
            wait_cnt <= '0;
            starved  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            starved  <= starved | (wait_cnt == WAIT_MAX);
        end
    end

    // Next state, wait count and the command/strobe mux
    always_comb begin
        state_next        = state;
        wait_cnt_next     = wait_cnt;
        o_Command         = CMD_IDLE;
        o_Address         = '0;
        o_Data_Write      = '0;
        o_Proc_Requested  = 1'b0;
        o_Proc_Read_Valid = 1'b0;
        o_Proc_Write_Done = 1'b0;
        o_Disp_Grant      = 1'b0;
        o_Disp_Read_Valid = 1'b0;

        case (state)
            S_PROC: begin
                o_Command         = i_Proc_Command;
                o_Address         = i_Proc_Address;
                o_Data_Write      = i_Proc_Data_Write;
                o_Proc_Requested  = i_Disp_Request;
                o_Proc_Read_Valid = i_Read_Valid;
                o_Proc_Write_Done = i_Write_Done;
                if (i_Proc_Yield && (i_Proc_Command == CMD_IDLE)) begin
                    state_next = S_GAP_D;
                end
            end
            S_GAP_D: state_next = S_DISP;
            S_DISP: begin
                // A display WRITE is illegal and is suppressed to IDLE
                o_Command         = (i_Disp_Command == CMD_WRITE) ? CMD_IDLE : i_Disp_Command;
                o_Address         = i_Disp_Address;
                o_Disp_Grant      = 1'b1;
                o_Disp_Read_Valid = i_Read_Valid;
                if (!i_Disp_Request && (i_Disp_Command == CMD_IDLE)) begin
                    state_next = S_GAP_P;
                end
            end
            S_GAP_P: state_next = S_PROC;
            default: state_next = S_PROC;
        endcase

        if (!i_Disp_Request) begin
            wait_cnt_next = '0;
        end else if ((state == S_PROC) && (state_next == S_GAP_D)) begin
            wait_cnt_next = '0;
        end else if ((state == S_PROC) && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt + TIMEOUT_WIDTH'(1);
        end
    end

    assign o_Starved = starved;

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench for sdram_client_arbiter: an ownership/handover model checked on
// every negative edge, plus literal expectations at key points of each scenario.
module tb_sdram_client_arbiter;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;
    localparam int unsigned TW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    proc_cmd = 2'd0;
    logic [AW-1:0] proc_addr = '0;
    logic [DW-1:0] proc_data = '0;
    logic          proc_yield = 1'b0;
    logic          disp_req = 1'b0;
    logic [1:0]    disp_cmd = 2'd0;
    logic [AW-1:0] disp_addr = '0;
    logic          rd_valid = 1'b0;
    logic          wr_done = 1'b0;

    logic          proc_requested, proc_rv, proc_wd, disp_grant, disp_rv, starved;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    int vectors = 0;
    int miscompares = 0;

    // Model: who owns the bus, whether a one-cycle handover is in flight, wait cycles
    bit m_disp = 1'b0;
    bit m_gap = 1'b0;
    int m_wait = 0;
    bit m_starved = 1'b0;
    bit m_in_proc;
    bit m_handoff;

    sdram_client_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .YIELD_TIMEOUT(TO), .TIMEOUT_WIDTH(TW)
    ) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_Proc_Command(proc_cmd), .i_Proc_Address(proc_addr),
        .i_Proc_Data_Write(proc_data), .i_Proc_Yield(proc_yield),
        .o_Proc_Requested(proc_requested), .o_Proc_Read_Valid(proc_rv),
        .o_Proc_Write_Done(proc_wd),
        .i_Disp_Request(disp_req), .i_Disp_Command(disp_cmd), .i_Disp_Address(disp_addr),
        .o_Disp_Grant(disp_grant), .o_Disp_Read_Valid(disp_rv),
        .o_Command(cmd), .o_Address(addr), .o_Data_Write(data),
        .i_Read_Valid(rd_valid), .i_Write_Done(wr_done),
        .o_Starved(starved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_disp = 1'b0; m_gap = 1'b0; m_wait = 0; m_starved = 1'b0;
        end else begin
            m_in_proc = !m_gap && !m_disp;
            m_handoff = m_in_proc && proc_yield && (proc_cmd == 2'd0);
            if (m_wait == int'(TO)) m_starved = 1'b1;
            if (!disp_req || m_handoff) m_wait = 0;
            else if (m_in_proc && m_wait < int'(TO)) m_wait = m_wait + 1;
            if (m_gap) m_gap = 1'b0;
            else if (m_handoff) begin m_gap = 1'b1; m_disp = 1'b1; end
            else if (m_disp && !disp_req && disp_cmd == 2'd0) begin m_gap = 1'b1; m_disp = 1'b0; end
        end
    end

    always @(negedge clk) begin
        bit ip, id;
        logic [1:0] ec;
        ip = !m_gap && !m_disp;
        id = !m_gap && m_disp;
        ec = ip ? proc_cmd : (id ? ((disp_cmd == 2'd2) ? 2'd0 : disp_cmd) : 2'd0);
        chk("m_cmd", 64'(cmd), 64'(ec));
        chk("m_addr", 64'(addr), ip ? 64'(proc_addr) : (id ? 64'(disp_addr) : 64'd0));
        chk("m_data", 64'(data), ip ? 64'(proc_data) : 64'd0);
        chk("m_req", 64'(proc_requested), 64'(ip && disp_req));
        chk("m_grant", 64'(disp_grant), 64'(id));
        chk("m_prv", 64'(proc_rv), 64'(ip && rd_valid));
        chk("m_pwd", 64'(proc_wd), 64'(ip && wr_done));
        chk("m_drv", 64'(disp_rv), 64'(id && rd_valid));
        chk("m_starved", 64'(starved), 64'(m_starved));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state with idle inputs
        step(); step();
        #1;
        chk("rst_req", 64'(proc_requested), 64'd0);
        chk("rst_grant", 64'(disp_grant), 64'd0);
        chk("rst_strobes", 64'({proc_rv, proc_wd, disp_rv}), 64'd0);
        chk("rst_starved", 64'(starved), 64'd0);
        rst = 1'b0;

        // 1: processor READ burst, strobes to processor only
        step();
        proc_cmd = 2'd1; proc_addr = 22'h000010;
        #1;
        chk("t1_cmd", 64'(cmd), 64'd1);
        chk("t1_addr", 64'(addr), 64'h10);
        for (int i = 0; i < 4; i++) begin
            step(); rd_valid = 1'b1; #1;
            chk("t1_prv", 64'(proc_rv), 64'd1);
            chk("t1_drv", 64'(disp_rv), 64'd0);
            step(); rd_valid = 1'b0;
        end

        // 2: display request during processor burst, then yield and one gap cycle
        disp_req = 1'b1; disp_addr = 22'h0002A0; #1;
        chk("t2_req", 64'(proc_requested), 64'd1);
        step(); step(); #1;
        chk("t2_nohandoff", 64'(disp_grant), 64'd0);
        proc_cmd = 2'd0; proc_yield = 1'b1;
        step(); proc_yield = 1'b0; rd_valid = 1'b1; #1;
        chk("t2_gap_cmd", 64'(cmd), 64'd0);
        chk("t5_gapd_strobes", 64'({proc_rv, disp_rv}), 64'd0);
        step(); rd_valid = 1'b0; #1;
        chk("t2_grant", 64'(disp_grant), 64'd1);
        chk("t2_addr", 64'(addr), 64'h2A0);

        // 3: display READ burst of 8, request drop mid-burst holds the grant
        disp_cmd = 2'd1;
        for (int i = 0; i < 8; i++) begin
            step(); rd_valid = 1'b1; wr_done = (i == 3); disp_addr = AW'(22'h0002A0 + i); #1;
            chk("t3_drv", 64'(disp_rv), 64'd1);
            chk("t3_pwd", 64'(proc_wd), 64'd0);
        end
        step(); rd_valid = 1'b0; wr_done = 1'b0; disp_cmd = 2'd2; #1;
        chk("t3_dwrite_cmd", 64'(cmd), 64'd0);
        disp_cmd = 2'd1; disp_req = 1'b0;
        step(); step(); #1;
        chk("t3_hold", 64'(disp_grant), 64'd1);
        disp_cmd = 2'd0; proc_cmd = 2'd2; proc_data = 32'hDEADBEEF;
        step(); rd_valid = 1'b1; #1;
        chk("t3_gap_grant", 64'(disp_grant), 64'd0);
        chk("t3_gap_cmd", 64'(cmd), 64'd0);
        chk("t5_gapp_strobes", 64'({proc_rv, disp_rv}), 64'd0);
        step(); rd_valid = 1'b0; #1;
        chk("t3_wr_cmd", 64'(cmd), 64'd2);
        chk("t3_wr_data", 64'(data), 64'hDEADBEEF);

        // 4: starvation after TO waiting cycles, sticky across handover
        proc_cmd = 2'd1; disp_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(); #1;
            if (k == 16) chk("t4_not_yet", 64'(starved), 64'd0);
            if (k == 17) chk("t4_starved", 64'(starved), 64'd1);
        end
        proc_cmd = 2'd0; proc_yield = 1'b1;
        step(); proc_yield = 1'b0;
        step(); #1;
        chk("t4_grant", 64'(disp_grant), 64'd1);
        chk("t4_sticky", 64'(starved), 64'd1);

        // 6: async reset mid display burst
        disp_cmd = 2'd1; proc_cmd = 2'd2; proc_addr = 22'h123456; proc_data = 32'h0BADF00D;
        step(); #1;
        rst = 1'b1; #1;
        chk("t6_grant", 64'(disp_grant), 64'd0);
        chk("t6_starved", 64'(starved), 64'd0);
        chk("t6_cmd", 64'(cmd), 64'd2);
        chk("t6_addr", 64'(addr), 64'h123456);
        step(); rst = 1'b0; disp_req = 1'b0; disp_cmd = 2'd0; proc_cmd = 2'd0;

        // Yield with no request: brief grant, then straight back through the gap
        step(); proc_yield = 1'b1;
        step(); proc_yield = 1'b0;
        step(); #1;
        chk("y_grant", 64'(disp_grant), 64'd1);
        step(); step(); #1;
        chk("y_back", 64'(disp_grant), 64'd0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
